// File: rtl/e1_capture_packer.sv
// e1_capture_packer: raw E1 line capture engine.
// Samples the tip/ring comparators of NCH lines through 2-flop synchronisers.
// Each sample tick forms a sample-set: line k puts tip at bit 2k and ring at bit 2k+1.
// Sample-sets are packed into bytes, oldest in the LSBs, and queued in a DEPTH-byte FIFO.
// With default parameters the stream is the E1 replay format: one byte per sample.
//
// Ports:
//   clk_16m    capture clock
//   rst        synchronous active-high reset
//   in_tip     raw tip comparator per line, asynchronous
//   in_ring    raw ring comparator per line, asynchronous
//   arm        start-capture pulse
//   trig_mode  0: start immediately, 1: start on first line activity
//   stop       end-capture pulse; wins over a simultaneous arm
//   out_data   packed sample byte
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data
//   overflow   sticky: a byte was dropped on a full FIFO
//   running    capture in progress (ARMED, RUN or FLUSH)
//   sample_cnt sample-sets captured since the last arm, saturating
module e1_capture_packer #(
   parameter int unsigned NCH   = 1,
   parameter int unsigned PACK  = 0,
   parameter int unsigned DIV   = 1,
   parameter int unsigned DEPTH = 16
) (
   input  logic           clk_16m,
   input  logic           rst,
   input  logic [NCH-1:0] in_tip,
   input  logic [NCH-1:0] in_ring,
   input  logic           arm,
   input  logic           trig_mode,
   input  logic           stop,
   output logic [7:0]     out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           overflow,
   output logic           running,
   output logic [31:0]    sample_cnt
);

   localparam int unsigned W   = 2 * NCH;
   localparam int unsigned SPB = (PACK != 0) ? 8 / W : 1;
   localparam int unsigned AW  = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StArmed, StRun, StFlush} state_e;

   state_e state_q, state_d;

   logic [NCH-1:0] tip_meta_q, tip_sync_q, ring_meta_q, ring_sync_q;
   logic [7:0]     set_byte, pack_new, pack_q, push_data_q;
   logic [2:0]     nsets_q;
   logic [7:0]     div_cnt_q;
   logic [31:0]    sample_cnt_q;
   logic           push_valid_q, overflow_q;
   logic           line_active, arm_go, tick, byte_done;

   logic [7:0]     mem_q [DEPTH];
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [AW:0]    mem_cnt_q;
   logic [7:0]     out_data_q;
   logic           out_valid_q;
   logic           pop, push_ok, load, drop;
   logic [31:0]    occ;

   // Synchronisers
   always_ff @(posedge clk_16m) begin
      if (rst) begin
         tip_meta_q  <= '0;
         tip_sync_q  <= '0;
         ring_meta_q <= '0;
         ring_sync_q <= '0;
      end else begin
         tip_meta_q  <= in_tip;
         tip_sync_q  <= tip_meta_q;
         ring_meta_q <= in_ring;
         ring_sync_q <= ring_meta_q;
      end
   end

   always_comb begin
      set_byte = '0;
      for (int k = 0; k < NCH; k++) begin
         set_byte[2*k]   = tip_sync_q[k];
         set_byte[2*k+1] = ring_sync_q[k];
      end
   end

   assign line_active = |{tip_sync_q, ring_sync_q};
   assign pack_new    = pack_q | (set_byte << (W * 32'(nsets_q)));
   assign byte_done   = (32'(nsets_q) + 32'd1) == SPB;

   // Control FSM
   always_ff @(posedge clk_16m) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      arm_go  = 1'b0;
      tick    = 1'b0;
      case (state_q)
         StIdle: begin
            if (arm && !stop) begin
               arm_go  = 1'b1;
               state_d = trig_mode ? StArmed : StRun;
            end
         end
         StArmed: begin
            if (stop) begin
               state_d = StFlush;
            end else if (line_active) begin
               // The triggering sample itself is sample-set 0.
               tick    = 1'b1;
               state_d = StRun;
            end
         end
         StRun: begin
            if (stop)                     state_d = StFlush;
            else if (div_cnt_q == 8'd0)   tick    = 1'b1;
         end
         StFlush: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Divider, packer and push stage
   always_ff @(posedge clk_16m) begin
      if (rst) begin
         pack_q       <= '0;
         nsets_q      <= '0;
         div_cnt_q    <= '0;
         sample_cnt_q <= '0;
         push_valid_q <= 1'b0;
         push_data_q  <= '0;
      end else begin
         push_valid_q <= 1'b0;
         if (arm_go) begin
            pack_q       <= '0;
            nsets_q      <= '0;
            div_cnt_q    <= '0;
            sample_cnt_q <= '0;
         end else if (tick) begin
            div_cnt_q <= 8'(DIV - 1);
            if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + 32'd1;
            if (byte_done) begin
               push_valid_q <= 1'b1;
               push_data_q  <= pack_new;
               pack_q       <= '0;
               nsets_q      <= '0;
            end else begin
               pack_q  <= pack_new;
               nsets_q <= nsets_q + 3'd1;
            end
         end else if (state_q == StRun && div_cnt_q != 8'd0) begin
            div_cnt_q <= div_cnt_q - 8'd1;
         end else if (state_q == StFlush && nsets_q != 3'd0) begin
            // Unused upper bits of pack_q are already zero.
            push_valid_q <= 1'b1;
            push_data_q  <= pack_q;
            pack_q       <= '0;
            nsets_q      <= '0;
         end
      end
   end

   // Output FIFO: memory plus a registered head; total occupancy is capped at DEPTH.
   assign pop     = out_valid_q && out_ready;
   assign occ     = 32'(mem_cnt_q) + 32'(out_valid_q);
   assign push_ok = push_valid_q && ((occ < DEPTH) || pop);
   assign load    = (!out_valid_q || pop) && (mem_cnt_q != '0);
   assign drop    = push_valid_q && !push_ok;

   always_ff @(posedge clk_16m) begin
      if (push_ok) mem_q[wptr_q] <= push_data_q;
   end

   always_ff @(posedge clk_16m) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         if (load) begin
            out_data_q  <= mem_q[rptr_q];
            out_valid_q <= 1'b1;
            rptr_q      <= rptr_q + AW'(1);
         end else if (pop) begin
            out_valid_q <= 1'b0;
         end
         if (push_ok && !load)      mem_cnt_q <= mem_cnt_q + (AW+1)'(1);
         else if (!push_ok && load) mem_cnt_q <= mem_cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_16m) begin
      if (rst)         overflow_q <= 1'b0;
      else if (drop)   overflow_q <= 1'b1;
      else if (arm_go) overflow_q <= 1'b0;
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign overflow   = overflow_q;
   assign running    = (state_q != StIdle);
   assign sample_cnt = sample_cnt_q;

endmodule
